// File: rtl/ubbcl_frame_accum.sv
// Seeds a 17-bit accumulator and sums LEN 9-bit samples through an external UBBCL adder.
// Latency: result valid the cycle after the last accepted beat; in_ready is low outside ACC, and the result holds while out_ready is low.
module ubbcl_frame_accum #(
    parameter int LEN   = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [16:0]      init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_data,
    output logic [8:0]       add_x,
    output logic [16:0]      add_y,
    input  logic [17:0]      add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [16:0]      out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    state_t           state_q, state_d;
    logic [16:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             beat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // in_ready depends on state only, so no combinational path from in_valid or out_ready
    assign in_ready = (state_q == S_ACC);
    assign beat     = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_valid = 1'b0;
        add_x     = 9'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = init;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                add_x = in_data;
                if (beat) begin
                    acc_d = add_s[16:0];
                    ovf_d = ovf_q | add_s[17];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign add_y     = acc_q;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_ubbcl_frame_accum.sv
module tb_ubbcl_frame_accum;
    localparam int LEN   = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [16:0]      init;
    logic             in_valid;
    logic             in_ready;
    logic [8:0]       in_data;
    logic [8:0]       add_x;
    logic [16:0]      add_y;
    logic [17:0]      add_s;
    logic             out_valid;
    logic             out_ready;
    logic [16:0]      out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    logic             start1;
    logic [16:0]      init1;
    logic             in_valid1;
    logic             in_ready1;
    logic [8:0]       in_data1;
    logic [8:0]       add_x1;
    logic [16:0]      add_y1;
    logic [17:0]      add_s1;
    logic             out_valid1;
    logic             out_ready1;
    logic [16:0]      out_sum1;
    logic             out_ovf1;
    logic [1:0]       out_count1;

    always #5 clk = ~clk;

    // Behavioural stand-ins for the external adders
    assign add_s  = {9'd0, add_x}  + {1'b0, add_y};
    assign add_s1 = {9'd0, add_x1} + {1'b0, add_y1};

    ubbcl_frame_accum #(.LEN(LEN), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init(init),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_x(add_x), .add_y(add_y), .add_s(add_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
    );

    ubbcl_frame_accum #(.LEN(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .init(init1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .add_x(add_x1), .add_y(add_y1), .add_s(add_s1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_ovf(out_ovf1), .out_count(out_count1)
    );

    typedef struct {
        logic [16:0] sum;
        logic        ovf;
        logic [4:0]  cnt;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] samp[$];
    int         errs   = 0;
    int         checks = 0;
    int         pops   = 0;
    int         pushes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer running total, wrapping at 2^17 and noting every wrap
    function automatic exp_t model(input logic [16:0] seed);
        exp_t        e;
        int unsigned run;
        run   = seed;
        e.ovf = 1'b0;
        foreach (samp[i]) begin
            run = run + samp[i];
            if (run >= 32'h20000) begin
                run   = run - 32'h20000;
                e.ovf = 1'b1;
            end
        end
        e.sum = run[16:0];
        e.cnt = 5'(samp.size());
        return e;
    endfunction

    // Monitor: pops on each output handshake and checks stability while stalled
    logic        held;
    logic [16:0] held_sum;
    logic        held_ovf;
    logic [4:0]  held_cnt;
    initial held = 1'b0;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (held) begin
                check("stall_sum", 32'(out_sum), 32'(held_sum));
                check("stall_ovf", 32'(out_ovf), 32'(held_ovf));
                check("stall_cnt", 32'(out_count), 32'(held_cnt));
            end
            if (out_ready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    pops++;
                    check("sb_sum", 32'(out_sum), 32'(e.sum));
                    check("sb_ovf", 32'(out_ovf), 32'(e.ovf));
                    check("sb_cnt", 32'(out_count), 32'(e.cnt));
                end
            end else begin
                held     = 1'b1;
                held_sum = out_sum;
                held_ovf = out_ovf;
                held_cnt = out_count;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame from the global samp queue; returns cycles from start edge to out_valid
    task automatic run_frame(input logic [16:0] seed, input int gapmax, input int bpmax,
                             input bit ign_start, output int lat);
        exp_t e;
        e = model(seed);
        sb.push_back(e);
        pushes++;
        start = 1'b1;
        init  = seed;
        tick();
        lat   = 1;
        start = 1'b0;
        init  = 17'($urandom);
        check("acc_ready", 32'(in_ready), 32'(1));
        foreach (samp[i]) begin
            int g;
            g = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data  = 9'($urandom);
                tick();
                lat++;
            end
            in_valid = 1'b1;
            in_data  = samp[i];
            if (ign_start && i == 3) begin
                start = 1'b1;
                init  = 17'($urandom);
            end
            tick();
            lat++;
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_data  = 9'($urandom);
        check("done_valid", 32'(out_valid), 32'(1));
        for (int k = 0; k < 8 && !out_valid; k++) begin
            tick();
            lat++;
        end
        if (bpmax > 0) begin
            int b;
            b = $urandom_range(bpmax, 1);
            for (int k = 0; k < b; k++) tick();
            check("bp_valid_held", 32'(out_valid), 32'(1));
        end
        out_ready = 1'b1;
        if (ign_start) begin
            start = 1'b1;
            init  = 17'($urandom);
        end
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("valid_fall", 32'(out_valid), 32'(0));
        check("idle_ready", 32'(in_ready), 32'(0));
    endtask

    task automatic check_reset_outs();
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_sum", 32'(out_sum), 32'(0));
        check("rst_out_ovf", 32'(out_ovf), 32'(0));
        check("rst_out_count", 32'(out_count), 32'(0));
        check("rst_add_x", 32'(add_x), 32'(0));
        check("rst_add_y", 32'(add_y), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [16:0] prev;
        rst_n = 1'b0; start = 1'b0; init = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        start1 = 1'b0; init1 = '0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        tick();
        tick();
        check_reset_outs();
        rst_n = 1'b1;
        tick();

        // Ramp 0..15 back-to-back
        samp.delete();
        for (int i = 0; i < 16; i++) samp.push_back(9'(i));
        run_frame(17'd0, 0, 0, 1'b0, lat);
        check("ramp_latency", 32'(lat), 32'(17));
        check("ramp_sum", 32'(out_sum), 32'(120));

        // Abort mid-frame with seven beats taken
        start = 1'b1; init = 17'h1234;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 9'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("pre_abort_cnt", 32'(out_count), 32'(7));
        rst_n = 1'b0;
        tick();
        check_reset_outs();
        rst_n = 1'b1;
        tick();
        check("abort_no_valid", 32'(out_valid), 32'(0));
        samp.delete();
        for (int i = 0; i < 16; i++) samp.push_back(9'd1);
        run_frame(17'd5, 0, 0, 1'b0, lat);
        check("post_rst_sum", 32'(out_sum), 32'(21));
        check("post_rst_ovf", 32'(out_ovf), 32'(0));
        check("post_rst_cnt", 32'(out_count), 32'(16));

        // Overflow, then a clean frame clears it
        samp.delete();
        samp.push_back(9'h1FF);
        for (int i = 0; i < 15; i++) samp.push_back(9'd0);
        run_frame(17'h1FFF0, 0, 2, 1'b0, lat);
        check("ovf_sum", 32'(out_sum), 32'h1EF);
        check("ovf_flag", 32'(out_ovf), 32'(1));
        samp.delete();
        for (int i = 0; i < 16; i++) samp.push_back(9'd2);
        run_frame(17'd0, 0, 0, 1'b0, lat);
        check("ovf_cleared", 32'(out_ovf), 32'(0));

        // Ignored start in ACC and in DONE alongside out_ready
        samp.delete();
        for (int i = 0; i < 16; i++) samp.push_back(9'($urandom));
        run_frame(17'h00777, 1, 0, 1'b1, lat);
        prev = model(17'h00777).sum;
        tick();
        check("ign_idle", 32'(in_ready), 32'(0));
        check("ign_hold_sum", 32'(out_sum), 32'(prev));

        // Random frames with valid gaps and output backpressure
        for (int f = 0; f < 8; f++) begin
            samp.delete();
            for (int i = 0; i < 16; i++) samp.push_back(9'($urandom));
            run_frame(17'($urandom), 3, 5, 1'b0, lat);
            check("rand_lat_min", 32'(lat >= 17), 32'(1));
        end

        // LEN=1 instance
        start1 = 1'b1; init1 = 17'd3;
        tick();
        start1 = 1'b0;
        check("l1_ready", 32'(in_ready1), 32'(1));
        check("l1_not_valid", 32'(out_valid1), 32'(0));
        in_valid1 = 1'b1; in_data1 = 9'h100;
        tick();
        in_valid1 = 1'b0;
        check("l1_valid", 32'(out_valid1), 32'(1));
        check("l1_sum", 32'(out_sum1), 32'(259));
        check("l1_cnt", 32'(out_count1), 32'(1));
        check("l1_ovf", 32'(out_ovf1), 32'(0));
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("l1_fall", 32'(out_valid1), 32'(0));

        tick();
        check("sb_drained", 32'(sb.size()), 32'(0));
        check("sb_pops", 32'(pops), 32'(pushes));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ubbcl_frame_accum.md
# ubbcl_frame_accum

Frame accumulator for the stage after the 9+17-bit unsigned block carry look-ahead adder (UBBCL). It drives that adder's operands and consumes its 18-bit sum. It seeds a 17-bit accumulator, then adds exactly LEN 9-bit samples from a valid/ready stream, one per accepted beat. It presents the final 17-bit total and a sticky carry-out flag on a valid/ready output port. The adder is combinational and instantiated beside this block; this block holds all state.

## Interface
- LEN, default 16: samples per frame; legal range 1..31.
- CNT_W, default 5: sample counter width; must satisfy 2^CNT_W > LEN.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low; one clock; the reset is synchronous and active-low.
- start  input  1  frame-start pulse; honoured only in IDLE.
- init  input  17  accumulator seed, captured on an honoured start.
- in_valid  input  1  sample valid.
- in_ready  output  1  sample ready.
- in_data  input  9  unsigned sample.
- add_x  output  9  adder operand X (9-bit port).
- add_y  output  17  adder operand Y (17-bit port).
- add_s  input  18  adder sum; add_s[17] is carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  result ready.
- out_sum  output  17  frame total modulo 2^17.
- out_ovf  output  1  sticky: set if any add in the frame produced add_s[17]=1.
- out_count  output  CNT_W  samples accumulated; equals LEN when out_valid is high.

## Operation
- State machine IDLE -> ACC -> DONE -> IDLE. Reset enters IDLE.
- IDLE: in_ready=0 and out_valid=0. If start=1: acc<=init, cnt<=0, ovf<=0, next state ACC. Otherwise hold all registers.
- ACC: in_ready=1. A beat is accepted when in_valid&in_ready. On acceptance: acc<=add_s[16:0], ovf<=ovf|add_s[17], cnt<=cnt+1. If cnt==LEN-1 at acceptance, next state DONE. With no beat, hold all registers.
- DONE: out_valid=1 and in_ready=0. When out_valid&out_ready, next state IDLE. acc, ovf and cnt hold until the next honoured start.
- Operand drive is combinational: add_y=acc in every state. add_x=in_data in ACC and 9'd0 otherwise.
- out_sum=acc, out_ovf=ovf and out_count=cnt, driven directly from registers.
- Arithmetic is unsigned. Each add is 9-bit + 17-bit with an 18-bit result. The accumulator wraps modulo 2^17, and the wrap is recorded only in out_ovf.
- start in ACC or DONE is ignored and has no side effect. This includes start in DONE in the same cycle as out_ready.
- in_data is ignored when in_valid=0 or the state is not ACC.
- add_s must be consistent with add_x and add_y in the same cycle; the block does not check this.
- rst_n=0 in any state, including mid-frame or with out_valid high, aborts the frame with no partial output.

## Timing
- Reset values, one edge after rst_n=0 is sampled: state=IDLE, acc=0, cnt=0, ovf=0.
- Output values in reset: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, out_count=0, add_x=0, add_y=0.
- start at edge t gives in_ready=1 in cycle t+1.
- The last accepted beat at edge t gives out_valid=1 in cycle t+1, with out_sum already final.
- Back-to-back: one sample per cycle while in_valid stays high. Minimum frame period is LEN+2 cycles: the start cycle, LEN beats, and the DONE cycle with out_ready=1.
- out_valid and all out_* values stay stable while out_ready=0. out_valid falls the cycle after the handshake.
- No combinational path from out_ready to in_ready or from in_valid to in_ready.
- There is a combinational path from in_data to add_x, through the external adder, to add_s, and into the register inputs. That path must close in one clk period.

## Test plan
- Reset check: drive rst_n low mid-ACC with cnt=7 -> next cycle all outputs 0, state IDLE. A following start with init=5 and 16 samples of 1 gives out_sum=21, out_ovf=0, out_count=16.
- LEN=16, init=0, samples 0..15 with in_valid held high -> out_valid exactly 17 cycles after start, out_sum=120, out_ovf=0.
- Overflow: init=17'h1FFF0, samples 9'h1FF then 15 zeros -> out_sum=17'h001EF, out_ovf=1. The next frame with init=0 gives out_ovf=0.
- Stalls: random in_valid gaps and random out_ready backpressure of up to 5 cycles -> totals match a software model, out_* stable while stalled, no beat dropped or duplicated.
- Ignored start: pulse start in ACC and again in DONE together with out_ready -> no reseed. The block returns to IDLE and out_sum holds the previous total.
- LEN=1: start, one sample 9'h100, init=17'd3 -> out_sum=259, out_count=1, out_valid two cycles after start.
